// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared types and width helpers for the clock meter
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int WIN_LOG2_DEF    = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // The window sum holds 2^win_log2 counts of cnt_w bits, so it never wraps.
  function automatic int sum_width(input int cnt_w, input int win_log2);
    return cnt_w + win_log2;
  endfunction

endpackage

// File: rtl/clk_meter_sync.sv
// rtl/clk_meter_sync.sv - meas_in synchronizer with rise/fall strobe generation
module clk_meter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic meas_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Shift the asynchronous input through the synchronizer, then one more flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & edge_q;

endmodule

// File: rtl/clk_meter.sv
// rtl/clk_meter.sv - period/high-time/jitter monitor; min/max tracking under CLK_METER_JITTER_EN
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_LOG2    = WIN_LOG2_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             start,
  input  logic [CNT_W-1:0] lo_limit,
  input  logic [CNT_W-1:0] hi_limit,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_last,
  output logic [CNT_W-1:0] high_last,
  output logic [CNT_W-1:0] period_avg,
  output logic [CNT_W-1:0] jitter_pp,
  output logic             out_of_range,
  output logic             overflow
);

  localparam int SUM_W = sum_width(CNT_W, WIN_LOG2);
  localparam int N_W   = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [N_W-1:0]   N_TARGET = N_W'(1) << WIN_LOG2;

  logic rise, fall;

  clk_meter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .meas_i(meas_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   plast_q, plast_d;
  logic [CNT_W-1:0]   hlast_q, hlast_d;
  logic [CNT_W-1:0]   avg_q, avg_d;
  logic               oor_q, oor_d;
  logic               ovf_q, ovf_d;
  logic               sat;
  logic [CNT_W-1:0]   period_w;
  logic [N_W-1:0]     n_inc;
`ifdef CLK_METER_JITTER_EN
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]   jit_q, jit_d;
`endif

  // Free-running period counter that restarts on every rise and sticks at all-ones.
  // Results are loaded on the cycle that enters DONE so they are already valid alongside meas_valid.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    sum_d    = sum_q;
    plast_d  = plast_q;
    hlast_d  = hlast_q;
    avg_d    = avg_q;
    oor_d    = oor_q;
    ovf_d    = ovf_q;
`ifdef CLK_METER_JITTER_EN
    min_d    = min_q;
    max_d    = max_q;
    jit_d    = jit_q;
`endif
    sat      = (cnt_q == CNT_MAX);
    period_w = sat ? CNT_MAX : cnt_q + CNT_W'(1);
    n_inc    = n_q + N_W'(1);

    if (rise)      cnt_d = '0;
    else if (!sat) cnt_d = cnt_q + CNT_W'(1);
    else           cnt_d = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          sum_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          oor_d   = 1'b0;
`ifdef CLK_METER_JITTER_EN
          min_d   = CNT_MAX;
          max_d   = '0;
`endif
        end
      end
      ARM: begin
        // The partial period in flight at start is discarded; counting begins at the first rise.
        if (rise) begin
          state_d = MEASURE;
          n_d     = '0;
        end
      end
      MEASURE: begin
        if (fall) hlast_d = period_w;
        if (rise) begin
          plast_d = period_w;
          sum_d   = sum_q + SUM_W'(period_w);
          n_d     = n_inc;
`ifdef CLK_METER_JITTER_EN
          if (period_w < min_q) min_d = period_w;
          if (period_w > max_q) max_d = period_w;
`endif
          if (n_inc == N_TARGET) begin
            state_d = DONE;
            avg_d   = sum_d[SUM_W-1:WIN_LOG2];
            oor_d   = (avg_d < lo_limit) || (avg_d > hi_limit);
`ifdef CLK_METER_JITTER_EN
            jit_d   = max_d - min_d;
`endif
          end
        end else if (sat) begin
          // Stuck or far-too-slow input: abort, keep the previous average.
          state_d = DONE;
          ovf_d   = 1'b1;
          oor_d   = 1'b1;
`ifdef CLK_METER_JITTER_EN
          jit_d   = '0;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      plast_q <= '0;
      hlast_q <= '0;
      avg_q   <= '0;
      oor_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CLK_METER_JITTER_EN
      min_q   <= '0;
      max_q   <= '0;
      jit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      plast_q <= plast_d;
      hlast_q <= hlast_d;
      avg_q   <= avg_d;
      oor_q   <= oor_d;
      ovf_q   <= ovf_d;
`ifdef CLK_METER_JITTER_EN
      min_q   <= min_d;
      max_q   <= max_d;
      jit_q   <= jit_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign meas_valid   = (state_q == DONE);
  assign period_last  = plast_q;
  assign high_last    = hlast_q;
  assign period_avg   = avg_q;
  assign out_of_range = oor_q;
  assign overflow     = ovf_q;
`ifdef CLK_METER_JITTER_EN
  assign jitter_pp    = jit_q;
`else
  assign jitter_pp    = '0;
`endif

endmodule

// File: tb/tb_clk_meter.sv
// tb/tb_clk_meter.sv - scoreboard bench for clk_meter (16-bit and 8-bit instances)
`timescale 1ns/1ps
module tb_clk_meter;

`ifdef CLK_METER_JITTER_EN
  localparam logic [15:0] JIT_ALT   = 16'd2;
  localparam logic [15:0] JIT_ASYNC = 16'd1;
`else
  localparam logic [15:0] JIT_ALT   = 16'd0;
  localparam logic [15:0] JIT_ASYNC = 16'd0;
`endif

  typedef struct {
    logic [15:0] plast;
    logic [15:0] hlast;
    logic [15:0] avg;
    logic [15:0] jit;
    logic        oor;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas, start;
  logic [15:0] lo_lim, hi_lim;
  logic        busy, valid, oor, ovf;
  logic [15:0] plast, hlast, avg, jit;

  logic        meas8, start8;
  logic [7:0]  lo8, hi8;
  logic        busy8, valid8, oor8, ovf8;
  logic [7:0]  plast8, hlast8, avg8, jit8;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int rise_strobes = 0;
  int in_rises = 0;

  int gen_mode = 0;
  int hi_ns = 30;
  int lo_ns = 50;
  int lo_alt_ns = 70;
  bit gen_alt = 1'b0;
  bit alt_phase = 1'b0;

  clk_meter #(.CNT_W(16), .WIN_LOG2(4), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .meas_in(meas), .start(start),
    .lo_limit(lo_lim), .hi_limit(hi_lim), .busy(busy), .meas_valid(valid),
    .period_last(plast), .high_last(hlast), .period_avg(avg), .jitter_pp(jit),
    .out_of_range(oor), .overflow(ovf)
  );

  clk_meter #(.CNT_W(8), .WIN_LOG2(4), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .meas_in(meas8), .start(start8),
    .lo_limit(lo8), .hi_limit(hi8), .busy(busy8), .meas_valid(valid8),
    .period_last(plast8), .high_last(hlast8), .period_avg(avg8), .jitter_pp(jit8),
    .out_of_range(oor8), .overflow(ovf8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_cnt++;
  always @(negedge clk) if (u_dut.u_sync.rise_o) rise_strobes++;
  always @(posedge meas) in_rises++;

  initial begin
    meas = 1'b0;
    @(posedge clk);
    #3;
    forever begin
      if (gen_mode == 0) begin
        meas = 1'b0;
        #10;
      end else begin
        meas = 1'b1;
        #(hi_ns);
        meas = 1'b0;
        if (alt_phase) #(lo_alt_ns);
        else           #(lo_ns);
        alt_phase = gen_alt ? ~alt_phase : 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(output bit got, output int cycles, input int budget);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic wait_valid8(output bit got, output int cycles, input int budget);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (valid8) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    #20;
    n_checks++; if ({busy, valid, oor, ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, valid, oor, ovf}); end
    n_checks++; if ({plast, hlast, avg, jit} !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {plast, hlast, avg, jit}); end
    n_checks++; if ({busy8, valid8, oor8, ovf8, plast8, avg8} !== 20'd0) begin n_fail++; $display("FAIL reset_dut8 got %h want 0", {busy8, valid8, oor8, ovf8, plast8, avg8}); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_steady();
    exp_t e;
    bit got;
    int cyc;
    lo_lim = 16'd7; hi_lim = 16'd9;
    gen_alt = 1'b0; gen_mode = 1;
    repeat (30) @(posedge clk);
    sb_q.push_back('{plast: 16'd8, hlast: 16'd3, avg: 16'd8, jit: 16'd0, oor: 1'b0, ovf: 1'b0});
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL steady_busy got %b want 1", busy); end
    wait_valid(got, cyc, 400);
    n_checks++; if (!got) begin n_fail++; $display("FAIL steady_timeout got none want meas_valid"); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if (plast !== e.plast) begin n_fail++; $display("FAIL steady_period got %0d want %0d", plast, e.plast); end
      n_checks++; if (hlast !== e.hlast) begin n_fail++; $display("FAIL steady_high got %0d want %0d", hlast, e.hlast); end
      n_checks++; if (avg !== e.avg) begin n_fail++; $display("FAIL steady_avg got %0d want %0d", avg, e.avg); end
      n_checks++; if ({oor, ovf} !== {e.oor, e.ovf}) begin n_fail++; $display("FAIL steady_flags got %b want %b", {oor, ovf}, {e.oor, e.ovf}); end
      n_checks++; if (jit !== e.jit) begin n_fail++; $display("FAIL steady_jitter got %0d want %0d", jit, e.jit); end
    end
    n_checks++; if (cyc < 16 * 8) begin n_fail++; $display("FAIL steady_latency got %0d want >= 128", cyc); end
    @(posedge clk); #1;
    n_checks++; if ({busy, valid} !== 2'b00) begin n_fail++; $display("FAIL steady_idle got %b want 00", {busy, valid}); end
  endtask

  task automatic test_alternate();
    exp_t e;
    bit got;
    int cyc;
    lo_lim = 16'd10; hi_lim = 16'd12;
    gen_alt = 1'b1;
    repeat (30) @(posedge clk);
    sb_q.push_back('{plast: 16'd0, hlast: 16'd3, avg: 16'd9, jit: JIT_ALT, oor: 1'b1, ovf: 1'b0});
    pulse_start();
    wait_valid(got, cyc, 400);
    n_checks++; if (!got) begin n_fail++; $display("FAIL alt_timeout got none want meas_valid"); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if (avg !== e.avg) begin n_fail++; $display("FAIL alt_avg got %0d want %0d", avg, e.avg); end
      n_checks++; if (jit !== e.jit) begin n_fail++; $display("FAIL alt_jitter got %0d want %0d", jit, e.jit); end
      n_checks++; if ({oor, ovf} !== {e.oor, e.ovf}) begin n_fail++; $display("FAIL alt_flags got %b want %b", {oor, ovf}, {e.oor, e.ovf}); end
      n_checks++; if (hlast !== e.hlast) begin n_fail++; $display("FAIL alt_high got %0d want %0d", hlast, e.hlast); end
    end
    n_checks++; if (plast !== 16'd8 && plast !== 16'd10) begin n_fail++; $display("FAIL alt_period got %0d want 8 or 10", plast); end
    gen_alt = 1'b0;
    lo_lim = 16'd7; hi_lim = 16'd9;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    bit got;
    int cyc;
    int base;
    repeat (30) @(posedge clk);
    base = valid_cnt;
    sb_q.push_back('{plast: 16'd8, hlast: 16'd3, avg: 16'd8, jit: 16'd0, oor: 1'b0, ovf: 1'b0});
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    wait_valid(got, cyc, 400);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_checks++; if (!got) begin n_fail++; $display("FAIL ign_timeout got none want meas_valid"); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if (avg !== e.avg || plast !== e.plast) begin n_fail++; $display("FAIL ign_result got %0d/%0d want %0d/%0d", avg, plast, e.avg, e.plast); end
    end
    repeat (250) @(posedge clk);
    #1;
    n_checks++; if (valid_cnt - base !== 1) begin n_fail++; $display("FAIL ign_count got %0d want 1", valid_cnt - base); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit got;
    int cyc;
    int base;
    pulse_start();
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, valid, oor, ovf} !== 4'b0) begin n_fail++; $display("FAIL rmid_flags got %b want 0000", {busy, valid, oor, ovf}); end
    n_checks++; if ({plast, hlast, avg, jit} !== 64'd0) begin n_fail++; $display("FAIL rmid_data got %h want 0", {plast, hlast, avg, jit}); end
    @(posedge clk); #1 rst_n = 1'b1;
    base = valid_cnt;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (valid_cnt !== base || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet got %0d valids busy %b want 0 valids busy 0", valid_cnt - base, busy); end
    sb_q.push_back('{plast: 16'd8, hlast: 16'd3, avg: 16'd8, jit: 16'd0, oor: 1'b0, ovf: 1'b0});
    pulse_start();
    wait_valid(got, cyc, 400);
    n_checks++; if (!got) begin n_fail++; $display("FAIL rmid_timeout got none want meas_valid"); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if ({plast, hlast, avg} !== {e.plast, e.hlast, e.avg}) begin n_fail++; $display("FAIL rmid_result got %0d/%0d/%0d want %0d/%0d/%0d", plast, hlast, avg, e.plast, e.hlast, e.avg); end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    bit got;
    int cyc;
    lo8 = 8'd1; hi8 = 8'd254;
    meas8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    n_checks++; if ({busy8, ovf8} !== 2'b10) begin n_fail++; $display("FAIL ovf_arm got %b want 10", {busy8, ovf8}); end
    sb_q.push_back('{plast: 16'd0, hlast: 16'd3, avg: 16'd0, jit: 16'd0, oor: 1'b1, ovf: 1'b1});
    meas8 = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 meas8 = 1'b0;
      end
      wait_valid8(got, cyc, 400);
    join
    n_checks++; if (!got) begin n_fail++; $display("FAIL ovf_timeout got none want meas_valid"); end
    n_checks++; if (cyc < 255 || cyc > 263) begin n_fail++; $display("FAIL ovf_latency got %0d want 255..263", cyc); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if ({ovf8, oor8} !== {e.ovf, e.oor}) begin n_fail++; $display("FAIL ovf_flags got %b want %b", {ovf8, oor8}, {e.ovf, e.oor}); end
      n_checks++; if (avg8 !== e.avg[7:0] || jit8 !== e.jit[7:0]) begin n_fail++; $display("FAIL ovf_avg got %0d/%0d want %0d/%0d", avg8, jit8, e.avg[7:0], e.jit[7:0]); end
      n_checks++; if (hlast8 !== e.hlast[7:0]) begin n_fail++; $display("FAIL ovf_high got %0d want %0d", hlast8, e.hlast[7:0]); end
    end
    @(posedge clk); #1;
    n_checks++; if ({busy8, valid8} !== 2'b00) begin n_fail++; $display("FAIL ovf_idle got %b want 00", {busy8, valid8}); end
  endtask

  task automatic test_async();
    exp_t e;
    bit got;
    int cyc;
    int rbase, ibase;
    gen_mode = 0;
    repeat (30) @(posedge clk);
    rbase = rise_strobes;
    ibase = in_rises;
    hi_ns = 40; lo_ns = 43;
    gen_mode = 1;
    sb_q.push_back('{plast: 16'd0, hlast: 16'd4, avg: 16'd8, jit: JIT_ASYNC, oor: 1'b0, ovf: 1'b0});
    pulse_start();
    wait_valid(got, cyc, 400);
    n_checks++; if (!got) begin n_fail++; $display("FAIL async_timeout got none want meas_valid"); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++; if (avg !== e.avg) begin n_fail++; $display("FAIL async_avg got %0d want %0d", avg, e.avg); end
      n_checks++; if (jit !== e.jit) begin n_fail++; $display("FAIL async_jitter got %0d want %0d", jit, e.jit); end
      n_checks++; if ({oor, ovf} !== {e.oor, e.ovf}) begin n_fail++; $display("FAIL async_flags got %b want %b", {oor, ovf}, {e.oor, e.ovf}); end
      n_checks++; if (hlast < e.hlast - 16'd1 || hlast > e.hlast + 16'd1) begin n_fail++; $display("FAIL async_high got %0d want %0d +-1", hlast, e.hlast); end
    end
    n_checks++; if (plast !== 16'd8 && plast !== 16'd9) begin n_fail++; $display("FAIL async_period got %0d want 8 or 9", plast); end
    gen_mode = 0;
    repeat (40) @(posedge clk);
    n_checks++; if (rise_strobes - rbase !== in_rises - ibase || in_rises - ibase < 17) begin
      n_fail++; $display("FAIL async_rises got %0d strobes want %0d input rises", rise_strobes - rbase, in_rises - ibase);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; start8 = 1'b0; meas8 = 1'b0;
    lo_lim = 16'd7; hi_lim = 16'd9; lo8 = 8'd1; hi8 = 8'd254;
    test_reset();
    test_steady();
    test_alternate();
    test_start_ignored();
    test_reset_mid();
    test_overflow();
    test_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
